// File: rtl/single_port_ram_arbiter_pkg.sv
// Shared types and default widths for the single-port RAM arbiter and its sequencers.
// No logic of its own.
// Used by the arbiter and by single_port_ram_ctrl.
package single_port_ram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    // Port ownership state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // Identity of the most recently served requester
    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

endpackage

// File: rtl/single_port_ram_arbiter_if.sv
// Bundle of both requester ports and the RAM macro port around the arbiter.
// Purely wiring; timing is set by the arbiter.
// master = arbiter side, slave = requesters plus RAM.
interface single_port_ram_arbiter_if
    import single_port_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // Requester A
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    // Requester B
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    // RAM macro
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_rdata,
        output a_ack, a_rvalid, a_rdata,
        output b_ack, b_rvalid, b_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_rdata,
        input  a_ack, a_rvalid, a_rdata,
        input  b_ack, b_rvalid, b_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/single_port_ram_arbiter.sv
// Two-requester arbiter for one single-port RAM with bounded-burst fairness.
// Latency: ack and RAM command combinational in the grant cycle; read data/rvalid one cycle later.
// Backpressure: a waiting requester holds req until acked; the owner keeps the port for up to BURST_MAX accesses.
import single_port_ram_pkg::*;

module single_port_ram_arbiter #(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    single_port_ram_arbiter_if.master  bus
);

    localparam int              CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    side_t            last, last_nxt;
    logic             gnt_a, gnt_b;

    // State register; reset leaves B as last served so A wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= SIDE_B;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Read-valid pipeline: a granted read returns data on the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
        end else begin
            bus.a_rvalid <= gnt_a & ~bus.a_we;
            bus.b_rvalid <= gnt_b & ~bus.b_we;
        end
    end

    // Grant decision and next state; counter saturates so a long solo run
    // hands over on the first cycle the other side asks
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        state_nxt = IDLE;
        cnt_nxt   = '0;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (bus.a_req && bus.b_req) begin
                    gnt_a = (last == SIDE_B);
                    gnt_b = (last == SIDE_A);
                end else begin
                    gnt_a = bus.a_req;
                    gnt_b = bus.b_req;
                end
            end
            OWN_A: begin
                if (bus.a_req && (!bus.b_req || cnt < CNT_MAX)) gnt_a = 1'b1;
                else if (bus.b_req)                             gnt_b = 1'b1;
            end
            OWN_B: begin
                if (bus.b_req && (!bus.a_req || cnt < CNT_MAX)) gnt_b = 1'b1;
                else if (bus.a_req)                             gnt_a = 1'b1;
            end
            default: ;
        endcase

        if (gnt_a) begin
            state_nxt = OWN_A;
            last_nxt  = SIDE_A;
            if (state == OWN_A) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            else                cnt_nxt = CNT_ONE;
        end else if (gnt_b) begin
            state_nxt = OWN_B;
            last_nxt  = SIDE_B;
            if (state == OWN_B) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            else                cnt_nxt = CNT_ONE;
        end
    end

    // RAM command mux; bus is driven to zero when nobody is granted
    always_comb begin
        bus.a_ack     = gnt_a;
        bus.b_ack     = gnt_b;
        bus.ram_en    = gnt_a | gnt_b;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (gnt_a) begin
            bus.ram_we    = bus.a_we;
            bus.ram_addr  = bus.a_addr;
            bus.ram_wdata = bus.a_wdata;
        end else if (gnt_b) begin
            bus.ram_we    = bus.b_we;
            bus.ram_addr  = bus.b_addr;
            bus.ram_wdata = bus.b_wdata;
        end
    end

    // Read data is shared; each side qualifies it with its own rvalid
    assign bus.a_rdata = bus.ram_rdata;
    assign bus.b_rdata = bus.ram_rdata;

endmodule
